// File: rtl/tt_dff_ram_seq.sv
// Flip-flop RAM with address pointer, auto-increment bursts and clear sequencer.
// Optional per-word even parity is enabled with TT_DFF_RAM_PARITY_EN.
module tt_dff_ram_seq #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_inc,
  input  logic              par_inj,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_perr,
  output logic              data_oe,
  output logic [ADDR_W-1:0] ptr,
  output logic              busy
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_X  = (ADDR_W+1)'(DEPTH - 1);

  logic [0:0]        state;
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic              rv_q;
  logic              in_range;
  logic              accept;
  logic              clr_wr;
  logic              clr_done;
  logic              do_wr;
  logic [ADDR_W-1:0] ptr_inc;
  logic [DATA_W-1:0] rd_word;
  logic              perr_next;

  assign busy      = (state == S_CLEAR);
  assign cmd_ready = ~busy & ena;
  assign accept    = cmd_valid & cmd_ready;
  assign in_range  = {1'b0, ptr} < DEPTH_X;
  assign clr_wr    = busy & ena;
  assign clr_done  = clr_wr & ({1'b0, ptr} == LAST_X);
  assign do_wr     = accept & (cmd_op == OP_WRITE) & in_range;
  assign rd_word   = in_range ? mem[ptr] : '0;
  assign rd_valid  = rv_q & ena;

  // Wrap at DEPTH, so an out-of-range pointer also returns to 0
  assign ptr_inc = ({1'b0, ptr} >= LAST_X) ? '0 : ptr + 1'b1;

`ifdef TT_DFF_RAM_PARITY_EN
  logic par [0:DEPTH-1];

  assign perr_next = in_range ? ((^mem[ptr]) ^ par[ptr]) : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_wr)
        par[ptr] <= 1'b0;
      else if (do_wr)
        par[ptr] <= (^cmd_data) ^ par_inj;
    end
  end
`else
  logic unused_inj;

  assign unused_inj = par_inj;
  assign perr_next  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_wr)
        mem[ptr] <= '0;
      else if (do_wr)
        mem[ptr] <= cmd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_CLEAR;
      ptr     <= '0;
      rd_data <= '0;
      rv_q    <= 1'b0;
      rd_perr <= 1'b0;
      data_oe <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      if (clr_wr) begin
        ptr <= clr_done ? '0 : ptr + 1'b1;
        if (clr_done)
          state <= S_IDLE;
      end else if (accept) begin
        unique case (cmd_op)
          OP_LOAD: begin
            ptr     <= cmd_addr;
            data_oe <= 1'b0;
          end
          OP_WRITE: begin
            data_oe <= 1'b0;
            if (cmd_inc)
              ptr <= ptr_inc;
          end
          OP_READ: begin
            rd_data <= rd_word;
            rd_perr <= perr_next;
            rv_q    <= 1'b1;
            data_oe <= 1'b1;
            if (cmd_inc)
              ptr <= ptr_inc;
          end
          OP_CLEAR: begin
            ptr   <= '0;
            state <= S_CLEAR;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/tt_dff_ram_seq.md
Name: tt_dff_ram_seq

Overview:
- Parametrised flip-flop RAM with an internal address pointer, auto-increment burst access and a hardware clear sequencer.
- Next generation of the team's byte-wide DFF RAM for the Tiny Tapeout harness. Adds configurable width and depth, a valid/ready command port, a registered read-valid strobe and a multi-cycle clear that replaces the single-cycle reset flush.
- Sits between the ui/uio pin wrapper and the user datapath.

Parameters:
- DATA_W, 8: word width in bits.
- ADDR_W, 4: pointer width.
- DEPTH, 16: number of words, 2 to 2^ADDR_W.

Ports:
- clk  in  1  : system clock, all logic on rising edge.
- rst  in  1  : synchronous reset, active-high.
- ena  in  1  : harness enable; when low the block freezes.
- cmd_valid  in  1  : command present.
- cmd_ready  out  1  : block accepts a command this cycle.
- cmd_op  in  2  : 00 LOAD_ADDR, 01 WRITE, 10 READ, 11 CLEAR_ALL.
- cmd_addr  in  ADDR_W  : pointer value for LOAD_ADDR.
- cmd_data  in  DATA_W  : write data.
- cmd_inc  in  1  : post-increment pointer after WRITE/READ.
- par_inj  in  1  : inverts stored parity on WRITE (PARITY_EN only).
- rd_data  out  DATA_W  : registered read data, held between reads.
- rd_valid  out  1  : one-cycle strobe, rd_data updated.
- rd_perr  out  1  : parity error on this read, qualified by rd_valid.
- data_oe  out  1  : pad output enable; high from first rd_valid until the next accepted WRITE or LOAD_ADDR.
- ptr  out  ADDR_W  : current address pointer.
- busy  out  1  : clear sequence in progress.

Behaviour:
- Two-state FSM, CLEAR and IDLE.
- Reset (rst=1 at a clock edge):
  - ptr=0, rd_data=0, rd_valid=0, rd_perr=0, data_oe=0.
  - FSM enters CLEAR; busy=1, cmd_ready=0.
  - rst has priority over everything, including a mid-clear or mid-command cycle.
- CLEAR state:
  - Each cycle with ena=1, writes 0 (and correct parity) to word[ptr], then ptr+1.
  - After writing word DEPTH-1: ptr=0, go to IDLE, busy=0. Total clear time is DEPTH ena-cycles.
  - With ena=0 the sequencer stalls, holding ptr.
- IDLE state: cmd_ready = ena. A command is accepted when cmd_valid & cmd_ready at a clock edge.
  - LOAD_ADDR: ptr <= cmd_addr; data_oe <= 0.
  - WRITE: if ptr < DEPTH, word[ptr] <= cmd_data, else the write is dropped. data_oe <= 0.
  - READ: next edge rd_data <= (ptr < DEPTH ? word[ptr] : 0), rd_valid=1 for exactly one cycle, data_oe <= 1. Latency is 1 cycle.
  - CLEAR_ALL: ptr <= 0, FSM to CLEAR, busy=1 next cycle. rd_data is held.
- Pointer increment:
  - After WRITE/READ with cmd_inc=1: ptr <= (ptr >= DEPTH-1) ? 0 : ptr+1. Wraps at DEPTH, not at 2^ADDR_W.
  - With cmd_inc=0, ptr is unchanged.
- Back-to-back:
  - One command per cycle. READ then WRITE to the same address on consecutive cycles returns the old data.
  - READ in the same cycle as a WRITE is impossible (single command port).
- ena=0: no state changes anywhere, rd_valid forced 0 that cycle. Memory and pointer are held.
- Memory contents are not reset except via the CLEAR sequence.

Optional Feature:
- Macro: TT_DFF_RAM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, written as ^cmd_data XOR par_inj.
  - On READ, rd_perr = (^stored_data) XOR stored_parity, registered with rd_data.
  - CLEAR writes parity 0.
  - Out-of-range reads give rd_perr=0.
- Undefined: no parity storage, rd_perr tied 0, par_inj ignored.

Test Plan:
- Clear after reset: assert rst 1 cycle → busy=1 for exactly 16 cycles, cmd_ready=0 throughout, then ptr=0. READ of all 16 addresses returns 0x00.
- Burst write/read with wrap: LOAD_ADDR 14, WRITE 0xA1, 0xB2, 0xC3 with cmd_inc=1 → ptr wraps 14→15→0→1. LOAD_ADDR 14, three READs with inc → rd_data 0xA1, 0xB2, 0xC3, each 1 cycle after acceptance, rd_valid single-cycle pulses.
- Boundary, DEPTH=12, ADDR_W=4: LOAD_ADDR 13, WRITE 0xFF → dropped; READ at 13 returns 0x00. inc from 11 goes to 0.
- ena gating: drop ena for 3 cycles mid-CLEAR → busy extends 3 cycles. Drop ena with cmd_valid held → cmd_ready=0, no write occurs.
- Reset/CLEAR_ALL mid-operation: write 0x55 at addr 3, issue CLEAR_ALL, assert rst on the 5th CLEAR cycle → clear restarts from ptr 0 and finishes 16 cycles after rst; addr 3 reads 0x00.
- Parity (TT_DFF_RAM_PARITY_EN): WRITE 0x07 at addr 2 with par_inj=1 and 0x07 at addr 4 with par_inj=0 → READ addr 2 gives rd_perr=1, addr 4 gives rd_perr=0, both rd_data=0x07.
